// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM timer with an APB4-style register slave.
//
// Shared prescaler and counter (edge- or center-aligned) drive CH_NUM compare
// channels with per-channel polarity. PRD and CRn are written into preload
// registers and copied into the active set on an overflow event, on CLR, and
// continuously while the timer is disabled.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   psel_i, penable_i,        APB4 control; an access phase is psel & penable
//   pwrite_i
//   paddr_i[5:0]              byte address, bits [1:0] ignored
//   pwdata_i[31:0]            write data
//   prdata_o[31:0]            read data, 0 outside a read access phase
//   pready_o                  tied to 1, no wait states
//   pslverr_o                 access phase to an unmapped address
//   pwm_o[CH_NUM-1:0]         registered channel outputs
//   irq_o                     registered overflow interrupt
module pwm_multi_ch #(
    parameter int CH_NUM     = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int PSCR_WIDTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [5:0]        paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic [CH_NUM-1:0] pwm_o,
    output logic              irq_o
);

    localparam logic [3:0] CH_LIMIT = 4'(CH_NUM);

    logic                  ovie_q, en_q, mode_q, dir_q, ovif_q;
    logic [CH_NUM-1:0]     pol_q;
    logic [PSCR_WIDTH-1:0] pscr_q, pscr_cnt_q;
    logic [CNT_WIDTH-1:0]  prd_pre_q, prd_act_q, cnt_q;
    logic [CNT_WIDTH-1:0]  cr_pre_q [CH_NUM];
    logic [CNT_WIDTH-1:0]  cr_act_q [CH_NUM];
    logic [CH_NUM-1:0]     pwm_q;
    logic                  irq_q;

    logic                  ovie_d, en_d, mode_d, dir_d, ovif_d;
    logic [CH_NUM-1:0]     pol_d;
    logic [PSCR_WIDTH-1:0] pscr_d, pscr_cnt_d;
    logic [CNT_WIDTH-1:0]  prd_pre_d, prd_act_d, cnt_d;
    logic [CNT_WIDTH-1:0]  cr_pre_d [CH_NUM];
    logic [CNT_WIDTH-1:0]  cr_act_d [CH_NUM];
    logic [CH_NUM-1:0]     pwm_d;
    logic                  irq_d;

    logic                  access, wr, rd, mapped;
    logic                  sel_ctrl, sel_pscr, sel_prd, sel_stat, sel_cnt, sel_cr;
    logic [2:0]            cr_idx;
    logic                  clr, tick, ovf, load;
    logic [CNT_WIDTH-1:0]  cnt_step;
    logic                  dir_step;
    logic [31:0]           rdata;

    assign access   = psel_i & penable_i;
    assign cr_idx   = paddr_i[4:2];
    assign sel_ctrl = (paddr_i[5:2] == 4'd0);
    assign sel_pscr = (paddr_i[5:2] == 4'd1);
    assign sel_prd  = (paddr_i[5:2] == 4'd2);
    assign sel_stat = (paddr_i[5:2] == 4'd3);
    assign sel_cnt  = (paddr_i[5:2] == 4'd4);
    assign sel_cr   = paddr_i[5] & ({1'b0, cr_idx} < CH_LIMIT);
    assign mapped   = sel_ctrl | sel_pscr | sel_prd | sel_stat | sel_cnt | sel_cr;
    assign wr       = access & pwrite_i & mapped;
    assign rd       = access & ~pwrite_i & mapped;

    assign pready_o  = 1'b1;
    assign pslverr_o = access & ~mapped;
    assign prdata_o  = rdata;
    assign pwm_o     = pwm_q;
    assign irq_o     = irq_q;

    // Next-state logic for every register; the register write path feeds the
    // shadow load directly so a preload written on an overflow edge is used
    // immediately.
    always_comb begin
        ovie_d = ovie_q;
        en_d   = en_q;
        mode_d = mode_q;
        pol_d  = pol_q;
        clr    = 1'b0;
        if (wr && sel_ctrl) begin
            ovie_d = pwdata_i[0];
            en_d   = pwdata_i[1];
            clr    = pwdata_i[2];
            mode_d = pwdata_i[3];
            pol_d  = pwdata_i[8 +: CH_NUM];
        end
        pscr_d    = (wr && sel_pscr) ? pwdata_i[PSCR_WIDTH-1:0] : pscr_q;
        prd_pre_d = (wr && sel_prd) ? pwdata_i[CNT_WIDTH-1:0] : prd_pre_q;
        for (int n = 0; n < CH_NUM; n++) begin
            cr_pre_d[n] = (wr && sel_cr && cr_idx == 3'(n)) ? pwdata_i[CNT_WIDTH-1:0]
                                                             : cr_pre_q[n];
        end

        tick = en_q && (pscr_cnt_q == pscr_q);
        if (!en_q)
            pscr_cnt_d = pscr_cnt_q;
        else if (tick)
            pscr_cnt_d = '0;
        else
            pscr_cnt_d = pscr_cnt_q + 1'b1;
        if ((wr && sel_pscr) || clr)
            pscr_cnt_d = '0;

        // Counter step for one tick. Comparisons use >= so a counter left
        // above a newly shortened period still turns around instead of
        // running to the top of its range.
        cnt_step = cnt_q;
        dir_step = dir_q;
        if (!mode_q) begin
            cnt_step = (cnt_q >= prd_act_q) ? '0 : cnt_q + 1'b1;
            dir_step = 1'b0;
        end else if (prd_act_q == '0) begin
            cnt_step = '0;
            dir_step = 1'b0;
        end else if (dir_q || cnt_q >= prd_act_q) begin
            cnt_step = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            dir_step = (cnt_step != '0);
        end else begin
            cnt_step = cnt_q + 1'b1;
            dir_step = 1'b0;
        end

        ovf   = tick && (cnt_step == '0);
        cnt_d = tick ? cnt_step : cnt_q;
        dir_d = tick ? dir_step : dir_q;
        if (clr) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end

        load      = ovf | clr | ~en_q;
        prd_act_d = load ? prd_pre_d : prd_act_q;
        for (int n = 0; n < CH_NUM; n++) begin
            cr_act_d[n] = load ? cr_pre_d[n] : cr_act_q[n];
        end

        // Set wins over a simultaneous write-1-to-clear.
        ovif_d = ovf | (ovif_q & ~(wr && sel_stat && pwdata_i[0]));
        irq_d  = ovif_d & ovie_d;

        for (int n = 0; n < CH_NUM; n++) begin
            pwm_d[n] = en_q ? ((cnt_q < cr_act_q[n]) ^ pol_q[n]) : pol_q[n];
        end
    end

    // Register bank with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovie_q     <= 1'b0;
            en_q       <= 1'b0;
            mode_q     <= 1'b0;
            pol_q      <= '0;
            pscr_q     <= '0;
            pscr_cnt_q <= '0;
            prd_pre_q  <= '0;
            prd_act_q  <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            ovif_q     <= 1'b0;
            pwm_q      <= '0;
            irq_q      <= 1'b0;
            for (int n = 0; n < CH_NUM; n++) begin
                cr_pre_q[n] <= '0;
                cr_act_q[n] <= '0;
            end
        end else begin
            ovie_q     <= ovie_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            pol_q      <= pol_d;
            pscr_q     <= pscr_d;
            pscr_cnt_q <= pscr_cnt_d;
            prd_pre_q  <= prd_pre_d;
            prd_act_q  <= prd_act_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            ovif_q     <= ovif_d;
            pwm_q      <= pwm_d;
            irq_q      <= irq_d;
            for (int n = 0; n < CH_NUM; n++) begin
                cr_pre_q[n] <= cr_pre_d[n];
                cr_act_q[n] <= cr_act_d[n];
            end
        end
    end

    // Read mux; preload values are what software sees for PRD and CRn.
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_ctrl) begin
                rdata[0]           = ovie_q;
                rdata[1]           = en_q;
                rdata[3]           = mode_q;
                rdata[8 +: CH_NUM] = pol_q;
            end
            if (sel_pscr) rdata[PSCR_WIDTH-1:0] = pscr_q;
            if (sel_prd)  rdata[CNT_WIDTH-1:0]  = prd_pre_q;
            if (sel_stat) begin
                rdata[0] = ovif_q;
                rdata[1] = dir_q;
            end
            if (sel_cnt)  rdata[CNT_WIDTH-1:0]  = cnt_q;
            for (int n = 0; n < CH_NUM; n++) begin
                if (sel_cr && cr_idx == 3'(n)) rdata[CNT_WIDTH-1:0] = cr_pre_q[n];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: self-checking bench for pwm_multi_ch (CH_NUM=4, 16-bit).
//
// The reference model tracks the timer as a phase within its period and
// derives the counter value and direction from that phase, updating once per
// clock from the bus signals the bench drives.
module tb_pwm_multi_ch;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          psel, penable, pwrite;
    logic [5:0]    paddr;
    logic [31:0]   pwdata, prdata;
    logic          pready, pslverr;
    logic [CH-1:0] pwm;
    logic          irq;

    pwm_multi_ch #(.CH_NUM(CH), .CNT_WIDTH(16), .PSCR_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
        .pready_o(pready), .pslverr_o(pslverr), .pwm_o(pwm), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_ovie, m_en, m_mode, m_ovif;
    bit [CH-1:0] m_pol;
    int unsigned m_pscr, m_prd_pre, m_prd_act, m_pc, m_phase;
    int unsigned m_cr_pre [CH];
    int unsigned m_cr_act [CH];
    bit [CH-1:0] e_pwm;
    bit          e_irq;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Counter value as a function of the position inside the period.
    function automatic int unsigned modelCnt();
        if (m_mode && m_phase > m_prd_act) return 2 * m_prd_act - m_phase;
        return m_phase;
    endfunction

    function automatic bit modelDir();
        return m_mode && (m_phase > m_prd_act);
    endfunction

    function automatic void modelRead(input logic [5:0] a, output bit ok, output logic [31:0] d);
        int w;
        w  = int'(a[5:2]);
        ok = 1'b1;
        d  = '0;
        case (w)
            0: d = (32'(m_pol) << 8) | (32'(m_mode) << 3) | (32'(m_en) << 1) | 32'(m_ovie);
            1: d = m_pscr;
            2: d = m_prd_pre;
            3: d = (32'(modelDir()) << 1) | 32'(m_ovif);
            4: d = modelCnt();
            default: begin
                if (w >= 8 && w < 8 + CH) d = m_cr_pre[w-8];
                else ok = 1'b0;
            end
        endcase
    endfunction

    function automatic logic [31:0] ctrlWord(bit ovie, bit en, bit clr, bit mode, bit [CH-1:0] pol);
        return (32'(pol) << 8) | (32'(mode) << 3) | (32'(clr) << 2) | (32'(en) << 1) | 32'(ovie);
    endfunction

    // One clock: predict from the current inputs, let the edge happen, then
    // compare the registered outputs.
    task automatic stepCycle();
        bit          n_ovie, n_en, n_mode, n_ovif, clr, w1c, wr, tick, ovf, load, n_irq;
        bit [CH-1:0] n_pol, n_pwm;
        int unsigned n_pscr, n_prd_pre, n_prd_act, n_pc, n_phase, period;
        int unsigned n_cr_pre [CH];
        int unsigned n_cr_act [CH];
        int          w;
        n_ovie = m_ovie; n_en = m_en; n_mode = m_mode; n_pol = m_pol;
        n_pscr = m_pscr; n_prd_pre = m_prd_pre; n_cr_pre = m_cr_pre;
        clr = 1'b0; w1c = 1'b0;
        wr = psel && penable && pwrite;
        w  = int'(paddr[5:2]);
        if (wr) begin
            if (w == 0) begin
                n_ovie = pwdata[0]; n_en = pwdata[1]; clr = pwdata[2];
                n_mode = pwdata[3]; n_pol = pwdata[8 +: CH];
            end
            if (w == 1) n_pscr = pwdata[15:0];
            if (w == 2) n_prd_pre = pwdata[15:0];
            if (w == 3) w1c = pwdata[0];
            if (w >= 8 && w < 8 + CH) n_cr_pre[w-8] = pwdata[15:0];
        end
        tick = m_en && (m_pc == m_pscr);
        if (!m_en) n_pc = m_pc;
        else if (tick) n_pc = 0;
        else n_pc = m_pc + 1;
        if ((wr && w == 1) || clr) n_pc = 0;
        if (m_mode) period = (m_prd_act == 0) ? 1 : 2 * m_prd_act;
        else        period = m_prd_act + 1;
        n_phase = tick ? (m_phase + 1) % period : m_phase;
        ovf = tick && (n_phase == 0);
        if (clr) n_phase = 0;
        load = ovf || clr || !m_en;
        n_prd_act = load ? n_prd_pre : m_prd_act;
        for (int c = 0; c < CH; c++) n_cr_act[c] = load ? n_cr_pre[c] : m_cr_act[c];
        n_ovif = ovf || (m_ovif && !w1c);
        n_irq  = n_ovif && n_ovie;
        for (int c = 0; c < CH; c++)
            n_pwm[c] = m_en ? ((modelCnt() < m_cr_act[c]) ^ m_pol[c]) : m_pol[c];

        @(posedge clk);
        if (rst) begin
            m_ovie = 0; m_en = 0; m_mode = 0; m_pol = '0; m_ovif = 0;
            m_pscr = 0; m_prd_pre = 0; m_prd_act = 0; m_pc = 0; m_phase = 0;
            for (int c = 0; c < CH; c++) begin m_cr_pre[c] = 0; m_cr_act[c] = 0; end
            e_pwm = '0; e_irq = 0;
        end else begin
            m_ovie = n_ovie; m_en = n_en; m_mode = n_mode; m_pol = n_pol; m_ovif = n_ovif;
            m_pscr = n_pscr; m_prd_pre = n_prd_pre; m_prd_act = n_prd_act;
            m_pc = n_pc; m_phase = n_phase; m_cr_pre = n_cr_pre; m_cr_act = n_cr_act;
            e_pwm = n_pwm; e_irq = n_irq;
        end
        #1;
        checkOutput("pwm", 32'(pwm), 32'(e_pwm));
        checkOutput("irq", 32'(irq), 32'(e_irq));
        if (!(psel && penable && !pwrite)) checkOutput("prdata_idle", prdata, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) stepCycle();
    endtask

    task automatic apbWrite(input logic [5:0] a, input logic [31:0] d);
        bit          ok;
        logic [31:0] unused;
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        stepCycle();
        penable = 1;
        #1;
        modelRead(a, ok, unused);
        checkOutput("pslverr_wr", 32'(pslverr), 32'(!ok));
        stepCycle();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apbRead(input logic [5:0] a);
        bit          ok;
        logic [31:0] d;
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        stepCycle();
        penable = 1;
        #1;
        modelRead(a, ok, d);
        checkOutput("prdata", prdata, d);
        checkOutput("pslverr_rd", 32'(pslverr), 32'(!ok));
        stepCycle();
        psel = 0; penable = 0;
    endtask

    // Randomised scenario: fresh configuration, then a mix of bus traffic.
    task automatic applyStimulus();
        int unsigned prd, mode, ovie;
        bit [CH-1:0] pol;
        logic [5:0]  addrs [12] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h20,
                                    6'h24, 6'h28, 6'h2C, 6'h30, 6'h14, 6'h3C};
        apbWrite(6'h00, 32'd0);
        prd  = $urandom_range(0, 9);
        mode = $urandom_range(0, 1);
        ovie = $urandom_range(0, 1);
        pol  = CH'($urandom);
        apbWrite(6'h04, $urandom_range(0, 2));
        apbWrite(6'h08, prd);
        for (int c = 0; c < CH; c++) apbWrite(6'(32 + 4 * c), $urandom_range(0, prd + 2));
        apbWrite(6'h00, ctrlWord(ovie[0], 1, 1, mode[0], pol));
        repeat (30) begin
            case ($urandom_range(0, 6))
                0: idle($urandom_range(1, 4));
                1: apbRead(addrs[$urandom_range(0, 11)]);
                2: apbWrite(6'(32 + 4 * $urandom_range(0, CH - 1)), $urandom_range(0, prd + 2));
                3: apbWrite(6'h0C, 32'd1);
                4: apbWrite(6'h04, $urandom_range(0, 2));
                5: begin
                    apbWrite(6'h00, ctrlWord(ovie[0], 0, 0, mode[0], pol));
                    idle($urandom_range(1, 3));
                    apbWrite(6'h00, ctrlWord(ovie[0], 1, 0, mode[0], pol));
                end
                default: apbWrite(($urandom_range(0, 1) != 0) ? 6'h30 : 6'h18, $urandom);
            endcase
        end
    endtask

    initial begin
        int hi;
        bit seen;
        rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        idle(2);
        checkOutput("reset_pwm", 32'(pwm), 32'd0);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        checkOutput("reset_pready", 32'(pready), 32'd1);
        checkOutput("reset_pslverr", 32'(pslverr), 32'd0);
        rst = 0;
        apbRead(6'h00);
        apbRead(6'h10);

        // Edge mode, PRD=9, CR0=3: 3 high out of every 10
        apbWrite(6'h08, 32'd9);
        apbWrite(6'h20, 32'd3);
        apbWrite(6'h00, ctrlWord(0, 1, 1, 0, 4'b0000));
        idle(5);
        hi = 0;
        repeat (10) begin stepCycle(); hi += int'(pwm[0]); end
        checkOutput("edge_duty", hi, 32'd3);
        repeat (10) apbRead(6'h10);

        // Prescaler 1: 6 high out of 20, then restart the tick phase
        apbWrite(6'h04, 32'd1);
        idle(3);
        hi = 0;
        repeat (20) begin stepCycle(); hi += int'(pwm[0]); end
        checkOutput("pscr_duty", hi, 32'd6);
        apbWrite(6'h04, 32'd1);
        idle(7);
        apbWrite(6'h04, 32'd0);

        // Compare change mid-period, then a compare above the period
        apbWrite(6'h20, 32'd8);
        idle(12);
        hi = 0;
        repeat (10) begin stepCycle(); hi += int'(pwm[0]); end
        checkOutput("cr8_duty", hi, 32'd8);
        apbWrite(6'h20, 32'd12);
        idle(12);
        hi = 0;
        repeat (10) begin stepCycle(); hi += int'(pwm[0]); end
        checkOutput("cr12_duty", hi, 32'd10);

        // Center mode PRD=4, CR1=2, POL1=1: low for 3 of every 8
        apbWrite(6'h00, 32'd0);
        apbWrite(6'h08, 32'd4);
        apbWrite(6'h24, 32'd2);
        apbWrite(6'h00, ctrlWord(0, 1, 1, 1, 4'b0010));
        idle(3);
        hi = 0;
        repeat (8) begin stepCycle(); hi += int'(!pwm[1]); end
        checkOutput("center_low", hi, 32'd3);
        repeat (8) apbRead(6'h0C);

        // Interrupt enable, clear, and OVIF without OVIE
        apbWrite(6'h00, ctrlWord(1, 1, 0, 1, 4'b0010));
        seen = 0;
        repeat (20) begin stepCycle(); if (irq) seen = 1; end
        checkOutput("irq_seen", 32'(seen), 32'd1);
        apbWrite(6'h0C, 32'd1);
        apbWrite(6'h00, ctrlWord(0, 1, 0, 1, 4'b0010));
        idle(20);
        checkOutput("irq_no_ovie", 32'(irq), 32'd0);
        apbRead(6'h0C);

        // W1C on a cycle with an overflow event (PRD=0: event every tick)
        apbWrite(6'h00, 32'd0);
        apbWrite(6'h08, 32'd0);
        apbWrite(6'h00, ctrlWord(1, 1, 1, 0, 4'b0000));
        idle(2);
        apbWrite(6'h0C, 32'd1);
        checkOutput("w1c_event_irq", 32'(irq), 32'd1);

        // Unmapped addresses
        apbRead(6'h30);
        apbRead(6'h14);
        apbWrite(6'h30, 32'hFFFF);
        apbWrite(6'h14, 32'h1234);
        apbRead(6'h20);

        // CLR while running keeps EN
        apbWrite(6'h08, 32'd9);
        apbWrite(6'h00, ctrlWord(0, 1, 1, 0, 4'b0000));
        idle(4);
        apbWrite(6'h00, ctrlWord(0, 1, 1, 0, 4'b0000));
        apbRead(6'h10);
        apbRead(6'h00);

        // Reset in the middle of a write access
        psel = 1; penable = 1; pwrite = 1; paddr = 6'h00; pwdata = ctrlWord(1, 1, 0, 1, 4'b1111);
        rst = 1;
        stepCycle();
        psel = 0; penable = 0; pwrite = 0; rst = 0;
        checkOutput("midrst_pwm", 32'(pwm), 32'd0);
        checkOutput("midrst_irq", 32'(irq), 32'd0);
        apbRead(6'h00);

        repeat (10) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
